tick_sequencer: RTL and testbench

- Global tick controller for a RANC core array (default 3x2 = 6 cores).
- Issues the broadcast `tick` pulse to every core, then waits for all neuron grids to report done and all routers to drain in-flight spikes, then issues the next tick.
- Runs a programmed number of ticks per `start`, with a watchdog and error capture.
- Sits above the core array, next to the host/CSR interface.

---
 rtl/tick_sequencer_pkg.sv | 22 ++
 rtl/tick_sequencer_if.sv | 25 ++
 rtl/tick_sequencer_quiet_window_counter.sv | 40 ++++
 rtl/tick_sequencer.sv | 165 ++++++++++++++++
 tb/tb_tick_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_sequencer_pkg.sv
// Shared types and constants for the RANC global tick sequencer.
package tick_seq_pkg;

  localparam int unsigned DEFAULT_NUM_CORES = 6;
  localparam int unsigned QUIET_CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_ERROR     = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CORE    = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ABORT   = 2'b11
  } err_code_e;

endpackage

// File: rtl/tick_sequencer_if.sv
// Core-array side of the tick sequencer: broadcast tick out, per-core status in.
interface tick_seq_core_if #(
  parameter int unsigned NUM_CORES = tick_seq_pkg::DEFAULT_NUM_CORES
) ();

  logic                 tick;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES-1:0] core_error;
  logic [NUM_CORES-1:0] router_idle;

  modport master (
    output tick,
    input  core_done,
    input  core_error,
    input  router_idle
  );

  modport slave (
    input  tick,
    output core_done,
    output core_error,
    output router_idle
  );

endinterface

// File: rtl/tick_sequencer_quiet_window_counter.sv
// Saturating count of consecutive idle cycles; reached_c flags the threshold.
module quiet_window_counter
  import tick_seq_pkg::*;
#(
  parameter int unsigned THRESHOLD = 8,
  parameter int unsigned CNT_W     = QUIET_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic idle,
  output logic reached_c
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any non-idle cycle restarts the window; hold at the threshold once there.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !idle) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign reached_c = (cnt_q == LIMIT);

endmodule

// File: rtl/tick_sequencer.sv
// Global tick controller: issues tick, waits for all cores done and routers quiet, repeats.
module tick_sequencer
  import tick_seq_pkg::*;
#(
  parameter int unsigned NUM_CORES    = DEFAULT_NUM_CORES,
  parameter int unsigned TICK_W       = 16,
  parameter int unsigned QUIET_CYCLES = 8,
  parameter int unsigned TIMEOUT_W    = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TICK_W-1:0] num_ticks,
  tick_seq_core_if.master   core_if,
  output logic              busy,
  output logic              run_done,
  output logic [TICK_W-1:0] tick_count,
  output logic              error,
  output logic [1:0]        error_code
);

  localparam logic [TIMEOUT_W-1:0] WD_MAX = {TIMEOUT_W{1'b1}};

  seq_state_e           state_q,      state_d;
  logic [TICK_W-1:0]    tick_count_q, tick_count_d;
  logic [TICK_W-1:0]    num_ticks_q,  num_ticks_d;
  logic [NUM_CORES-1:0] done_mask_q,  done_mask_d;
  logic [TIMEOUT_W-1:0] wd_q,         wd_d;
  logic                 tick_q,       tick_d;
  logic                 busy_q,       busy_d;
  logic                 run_done_q,   run_done_d;
  logic                 error_q,      error_d;
  err_code_e            error_code_q, error_code_d;
  logic                 quiet_reached_c;

  quiet_window_counter #(
    .THRESHOLD (QUIET_CYCLES),
    .CNT_W     (QUIET_CNT_W)
  ) u_quiet (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (state_q != ST_DRAIN),
    .idle      (&core_if.router_idle),
    .reached_c (quiet_reached_c)
  );

  always_comb begin
    state_d      = state_q;
    tick_count_d = tick_count_q;
    num_ticks_d  = num_ticks_q;
    done_mask_d  = done_mask_q;
    wd_d         = wd_q;
    error_d      = error_q;
    error_code_d = error_code_q;
    run_done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_ticks_d  = num_ticks;
          tick_count_d = '0;
          error_d      = 1'b0;
          error_code_d = ERR_NONE;
          if (num_ticks == '0) begin
            run_done_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      // Done pulses seen during the tick cycle belong to the previous tick.
      ST_ISSUE: begin
        done_mask_d = '0;
        wd_d        = '0;
        state_d     = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wd_d        = wd_q + TIMEOUT_W'(1);
        done_mask_d = done_mask_q | core_if.core_done;
        if (&done_mask_d) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        wd_d = wd_q + TIMEOUT_W'(1);
        if (quiet_reached_c) begin
          tick_count_d = tick_count_q + TICK_W'(1);
          if (tick_count_d == num_ticks_q) begin
            run_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Faults applied lowest priority first so later overrides win.
    if ((state_q == ST_WAIT_DONE || state_q == ST_DRAIN) && wd_d == WD_MAX) begin
      state_d      = ST_ERROR;
      error_d      = 1'b1;
      error_code_d = ERR_TIMEOUT;
      run_done_d   = 1'b0;
      tick_count_d = tick_count_q;
    end
    if (state_q != ST_IDLE && state_q != ST_ERROR && |core_if.core_error) begin
      state_d      = ST_ERROR;
      error_d      = 1'b1;
      error_code_d = ERR_CORE;
      run_done_d   = 1'b0;
      tick_count_d = tick_count_q;
    end
    if (state_q != ST_IDLE && abort) begin
      state_d      = ST_IDLE;
      error_d      = 1'b1;
      error_code_d = ERR_ABORT;
      run_done_d   = 1'b0;
      tick_count_d = tick_count_q;
    end

    tick_d = (state_d == ST_ISSUE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tick_count_q <= '0;
      num_ticks_q  <= '0;
      done_mask_q  <= '0;
      wd_q         <= '0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      tick_count_q <= tick_count_d;
      num_ticks_q  <= num_ticks_d;
      done_mask_q  <= done_mask_d;
      wd_q         <= wd_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      run_done_q   <= run_done_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
    end
  end

  assign core_if.tick = tick_q;
  assign busy         = busy_q;
  assign run_done     = run_done_q;
  assign tick_count   = tick_count_q;
  assign error        = error_q;
  assign error_code   = error_code_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Scoreboard bench for tick_sequencer: directed runs, expected events and state probes queued ahead.
module tb_tick_sequencer;
  import tick_seq_pkg::*;

  localparam int unsigned NC  = 6;
  localparam int unsigned TW  = 16;
  localparam int unsigned QC  = 8;
  localparam int unsigned TOW = 6;
  // Done at tick+6 gives 6 WAIT cycles, QC+1 DRAIN cycles, plus the tick cycle.
  localparam int NORM_PERIOD = 6 + int'(QC) + 2;

  typedef enum int {EV_TICK, EV_DONE, EV_ERR} ev_e;
  typedef struct {ev_e kind; int cyc; int count; int code;} ev_t;
  typedef struct {int cyc; int busy; int tick; int rd; int err; int code; int count;} probe_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [TW-1:0] num_ticks = '0;
  logic          busy;
  logic          run_done;
  logic [TW-1:0] tick_count;
  logic          error;
  logic [1:0]    error_code;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  ev_t    evq[$];
  probe_t prq[$];
  int     dly [NC] = '{default: 6};
  int     glitch_cyc = -1;
  int     tick_cyc = -100000;
  bit     tb_done = 1'b0;
  bit     err_prev = 1'b0;

  tick_seq_core_if #(.NUM_CORES(NC)) cif ();

  tick_sequencer #(
    .NUM_CORES    (NC),
    .TICK_W       (TW),
    .QUIET_CYCLES (QC),
    .TIMEOUT_W    (TOW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .num_ticks  (num_ticks),
    .core_if    (cif.master),
    .busy       (busy),
    .run_done   (run_done),
    .tick_count (tick_count),
    .error      (error),
    .error_code (error_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core array model: core i pulses done dly[i] cycles after each tick (0 = never).
  initial begin
    cif.core_done   = '0;
    cif.router_idle = '1;
    forever begin
      @(posedge clk);
      #1;
      if (cif.tick === 1'b1) tick_cyc = cyc;
      for (int i = 0; i < int'(NC); i++)
        cif.core_done[i] = (dly[i] != 0) && (cyc - tick_cyc == dly[i]);
      cif.router_idle    = '1;
      cif.router_idle[1] = (cyc != glitch_cyc);
    end
  end

  task automatic cmp(string nm, int want, int got_v);
    if (want >= 0) begin
      checks++;
      if (want != got_v) begin
        errors++;
        $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, got_v, want);
      end
    end
  endtask

  task automatic got(ev_e k, int cnt, int code);
    ev_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d, expected none", k.name(), cyc);
      return;
    end
    e = evq.pop_front();
    if (e.kind != k || e.cyc != cyc) begin
      errors++;
      $display("FAIL event_order: got %s at cycle %0d, expected %s at cycle %0d",
               k.name(), cyc, e.kind.name(), e.cyc);
    end
    if (k == EV_DONE) cmp("done_tick_count", e.count, cnt);
    if (k == EV_ERR)  cmp("fault_error_code", e.code, code);
  endtask

  task automatic check_probes();
    for (int i = prq.size() - 1; i >= 0; i--) begin
      if (prq[i].cyc == cyc) begin
        cmp("busy",       prq[i].busy,  int'(busy));
        cmp("tick",       prq[i].tick,  int'(cif.tick));
        cmp("run_done",   prq[i].rd,    int'(run_done));
        cmp("error",      prq[i].err,   int'(error));
        cmp("error_code", prq[i].code,  int'(error_code));
        cmp("tick_count", prq[i].count, int'(tick_count));
        prq.delete(i);
      end else if (prq[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL probe_missed: probe for cycle %0d still pending at cycle %0d", prq[i].cyc, cyc);
        prq.delete(i);
      end
    end
  endtask

  // Monitor: pop an expectation whenever the DUT presents an event, then apply state probes.
  initial begin
    forever begin
      @(negedge clk);
      if (cif.tick === 1'b1) got(EV_TICK, 0, 0);
      if (run_done === 1'b1) got(EV_DONE, int'(tick_count), 0);
      if (error === 1'b1 && !err_prev) got(EV_ERR, 0, int'(error_code));
      err_prev = (error === 1'b1);
      check_probes();
      if (tb_done || cyc > 4000) begin
        if (!tb_done) begin
          checks++;
          errors++;
          $display("FAIL timeout: bench stalled at cycle %0d", cyc);
        end
        cmp("pending_events", 0, evq.size());
        cmp("pending_probes", 0, prq.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void exp_ev(ev_e k, int c, int cnt, int code);
    evq.push_back('{k, c, cnt, code});
  endfunction

  function automatic void probe(int c, int b, int t, int r, int e, int cd, int cnt);
    prq.push_back('{c, b, t, r, e, cd, cnt});
  endfunction

  task automatic launch(int n);
    start     = 1'b1;
    num_ticks = TW'(n);
    step(1);
    start     = 1'b0;
  endtask

  initial begin : stim
    int t0;
    int t1;
    int c;
    cif.core_error = '0;

    // Reset state
    step(2);
    probe(cyc, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step(2);

    // Normal run: 3 ticks, 16 cycles apart
    t0 = cyc + 1;
    for (int k = 0; k < 3; k++) exp_ev(EV_TICK, t0 + k * NORM_PERIOD, 0, 0);
    exp_ev(EV_DONE, t0 + 3 * NORM_PERIOD, 3, 0);
    probe(t0, 1, 1, 0, 0, 0, 0);
    probe(t0 + 3 * NORM_PERIOD, 0, 0, 1, 0, 0, 3);
    launch(3);
    step(t0 + 3 * NORM_PERIOD + 4 - cyc);

    // Staggered done, router glitch at quiet count 5 on the first tick: 17 + 6 cycles
    dly = '{2, 3, 4, 5, 6, 7};
    t0 = cyc + 1;
    glitch_cyc = t0 + 13;
    exp_ev(EV_TICK, t0, 0, 0);
    exp_ev(EV_TICK, t0 + 23, 0, 0);
    exp_ev(EV_DONE, t0 + 40, 2, 0);
    launch(2);
    step(t0 + 44 - cyc);
    glitch_cyc = -1;
    dly = '{default: 6};

    // Zero ticks: run_done next cycle, never busy
    t0 = cyc + 1;
    exp_ev(EV_DONE, t0, 0, 0);
    for (int k = 0; k < 5; k++) probe(t0 + k, 0, 0, -1, 0, 0, 0);
    launch(0);
    step(6);

    // Watchdog: core 4 silent, error seen after 63 watchdog counts
    dly[4] = 0;
    t0 = cyc + 1;
    exp_ev(EV_TICK, t0, 0, 0);
    exp_ev(EV_ERR, t0 + 64, 0, 2);
    probe(t0 + 63, 1, 0, 0, 0, 0, 0);
    probe(t0 + 64, 1, 0, 0, 1, 2, 0);
    launch(1);
    step(t0 + 66 - cyc);
    c = cyc;
    probe(c + 1, 1, 0, 0, 1, 2, 0);
    probe(c + 3, 1, 0, 0, 1, 2, 0);
    launch(5);
    step(4);
    c = cyc;
    probe(c + 1, 0, 0, 0, 1, 3, 0);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(3);
    dly[4] = 6;

    // Abort and core_error together in DRAIN: abort wins
    t0 = cyc + 1;
    exp_ev(EV_TICK, t0, 0, 0);
    exp_ev(EV_ERR, t0 + 11, 0, 3);
    probe(t0 + 11, 0, 0, 0, 1, 3, 0);
    launch(2);
    step(10);
    cif.core_error = 6'b000100;
    abort = 1'b1;
    step(1);
    cif.core_error = '0;
    abort = 1'b0;
    step(25);

    // Core error alone in DRAIN: ERROR state, code held until abort
    t0 = cyc + 1;
    exp_ev(EV_TICK, t0, 0, 0);
    exp_ev(EV_ERR, t0 + 11, 0, 1);
    probe(t0 + 11, 1, 0, 0, 1, 1, 0);
    probe(t0 + 14, 1, 0, 0, 1, 1, 0);
    launch(2);
    step(10);
    cif.core_error = 6'b000100;
    step(1);
    cif.core_error = '0;
    step(5);
    probe(cyc + 1, 0, 0, 0, 1, 3, 0);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(3);

    // Reset during WAIT_DONE of tick 2, then a clean single-tick run
    t0 = cyc + 1;
    exp_ev(EV_TICK, t0, 0, 0);
    exp_ev(EV_TICK, t0 + NORM_PERIOD, 0, 0);
    probe(t0 + 19, 1, 0, 0, 0, 0, 1);
    probe(t0 + 20, 0, 0, 0, 0, 0, 0);
    launch(3);
    step(t0 + 19 - cyc);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(5);
    t1 = cyc + 1;
    exp_ev(EV_TICK, t1, 0, 0);
    exp_ev(EV_DONE, t1 + NORM_PERIOD, 1, 0);
    probe(t1 + NORM_PERIOD, 0, 0, 1, 0, 0, 1);
    launch(1);
    step(t1 + NORM_PERIOD + 4 - cyc);

    tb_done = 1'b1;
    step(2);
  end

endmodule
